dilated_tap_cache: RTL and testbench



---
 rtl/dtc_pkg.sv | 21 ++
 rtl/dtc_ring_mem.sv | 28 ++
 rtl/dilated_tap_cache.sv | 83 ++++++++
 tb/tb_dilated_tap_cache.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared helpers for dilated_tap_cache: ring sizing and wrapped address arithmetic.
// Optional build macro used by the top: DTC_ZERO_MASK_EN.
package dtc_pkg;

   function automatic int num_entries(input int dilation, input int kernel_size);
      return dilation * (kernel_size - 1);
   endfunction

   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Wraps by adding n rather than truncating, so non-power-of-2 depths stay correct.
   function automatic int ring_sub(input int head, input int lag, input int n);
      int a;
      a = head - lag;
      if (a < 0) a = a + n;
      return a;
   endfunction

endpackage

// File: rtl/dtc_ring_mem.sv
// N-entry sample store: one synchronous write port and RP combinational read ports.
module dtc_ring_mem #(
   parameter int N      = 12,
   parameter int ADDR_W = 4,
   parameter int DW     = 64,
   parameter int RP     = 3
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic [ADDR_W-1:0] rd_addr [RP],
   output logic [DW-1:0]     rd_data [RP]
);

   // NOTE: the array has no reset branch; history validity is tracked by the
   // fill counter in the top, and a resettable array would not map to RAM.
   logic [DW-1:0] mem [N] = '{default: '0};

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_comb begin
      for (int j = 0; j < RP; j++) rd_data[j] = mem[rd_addr[j]];
   end

endmodule

// File: rtl/dilated_tap_cache.sv
// Ring-buffer cache presenting KERNEL_SIZE dilated taps per accepted sample.
// Define DTC_ZERO_MASK_EN to zero taps whose lag exceeds the recorded history.
module dilated_tap_cache
   import dtc_pkg::*;
#(
   parameter int W           = 16,
   parameter int D           = 4,
   parameter int DILATION    = 4,
   parameter int KERNEL_SIZE = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [D*W-1:0]              inp,
   output logic                        out_valid,
   output logic [KERNEL_SIZE*D*W-1:0]  out_taps,
   output logic                        out_primed
);

   localparam int N      = num_entries(DILATION, KERNEL_SIZE);
   localparam int ADDR_W = addr_width(N);
   localparam int DW     = D * W;
   localparam int RP     = KERNEL_SIZE - 1;
   localparam int FILL_W = $clog2(N + 1);

   logic [ADDR_W-1:0]         head;
   logic [FILL_W-1:0]         fill;
   logic [ADDR_W-1:0]         rd_addr [RP];
   logic [DW-1:0]             rd_data [RP];
   logic [KERNEL_SIZE*DW-1:0] taps;
   logic                      accept;

   // rst has priority: a sample presented during reset is not written.
   assign accept = in_valid & ~rst;

   dtc_ring_mem #(.N(N), .ADDR_W(ADDR_W), .DW(DW), .RP(RP)) u_mem (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (head),
      .wr_data (inp),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Lag N lands on head itself and reads the entry before this cycle's write.
   always_comb begin
      for (int k = 0; k < RP; k++)
         rd_addr[k] = ADDR_W'(ring_sub(int'(head), (RP - k) * DILATION, N));
   end

   // NOTE: taps is assigned a full default first so no path can infer a latch.
   always_comb begin
      taps = '0;
      taps[RP*DW +: DW] = inp;
      for (int k = 0; k < RP; k++) begin
         taps[k*DW +: DW] = rd_data[k];
`ifdef DTC_ZERO_MASK_EN
         if ((RP - k) * DILATION > int'(fill)) taps[k*DW +: DW] = '0;
`endif
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values (out_primed sees fill before its increment).
   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         fill       <= '0;
         out_valid  <= 1'b0;
         out_primed <= 1'b0;
         out_taps   <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            head       <= (head == ADDR_W'(N - 1)) ? '0 : head + ADDR_W'(1);
            if (fill < FILL_W'(N)) fill <= fill + FILL_W'(1);
            out_taps   <= taps;
            out_primed <= (fill >= FILL_W'(N));
         end
      end
   end

endmodule

// File: tb/tb_dilated_tap_cache.sv
// Directed and random checks of dilated_tap_cache across several parameter sets.
module tb_dilated_tap_cache;

   logic        clk = 1'b0;
   logic [4:0]  rst = 5'b11111;
   logic [4:0]  in_valid = '0;
   logic [63:0] data = '0;
   int          sel = 0;

   logic [4:0]   ov, pr;
   logic [63:0]  t0, t1;
   logic [47:0]  t2;
   logic [31:0]  t3;
   logic [255:0] t4;

   logic [255:0] gt;
   logic         gv, gp;

   int errors = 0;
   int checks = 0;

   logic [63:0]  hist [$];
   logic [255:0] last_exp;
   logic         last_pr;

   always #5 clk = ~clk;

   // 0: A (D1,DIL2,K4)  1: G same params  2: B (DIL3,K3)  3: C (DIL1,K2)  4: R defaults
   dilated_tap_cache #(.W(16), .D(1), .DILATION(2), .KERNEL_SIZE(4)) u_a (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .inp(data[15:0]),
      .out_valid(ov[0]), .out_taps(t0), .out_primed(pr[0]));
   dilated_tap_cache #(.W(16), .D(1), .DILATION(2), .KERNEL_SIZE(4)) u_g (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .inp(data[15:0]),
      .out_valid(ov[1]), .out_taps(t1), .out_primed(pr[1]));
   dilated_tap_cache #(.W(16), .D(1), .DILATION(3), .KERNEL_SIZE(3)) u_b (
      .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .inp(data[15:0]),
      .out_valid(ov[2]), .out_taps(t2), .out_primed(pr[2]));
   dilated_tap_cache #(.W(16), .D(1), .DILATION(1), .KERNEL_SIZE(2)) u_c (
      .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .inp(data[15:0]),
      .out_valid(ov[3]), .out_taps(t3), .out_primed(pr[3]));
   dilated_tap_cache u_r (
      .clk(clk), .rst(rst[4]), .in_valid(in_valid[4]), .inp(data),
      .out_valid(ov[4]), .out_taps(t4), .out_primed(pr[4]));

   always_comb begin
      case (sel)
         0:       gt = 256'(t0);
         1:       gt = 256'(t1);
         2:       gt = 256'(t2);
         3:       gt = 256'(t3);
         default: gt = t4;
      endcase
      gv = ov[sel];
      gp = pr[sel];
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int s, input logic r, input logic v, input logic [63:0] d);
      sel = s;
      rst = '0;
      in_valid = '0;
      rst[s] = r;
      in_valid[s] = v;
      data = d;
      @(posedge clk);
      #1;
   endtask

   // Expected taps from the full accepted history (last entry is the current sample).
   function automatic logic [255:0] exp_taps(input int k, input int dil, input int ew);
      logic [255:0] r;
      logic [63:0]  mask;
      int           idx;
      r = '0;
      mask = (64'd1 << ew) - 64'd1;
      for (int j = 0; j < k; j++) begin
         idx = hist.size() - 1 - (k - 1 - j) * dil;
         if (idx >= 0) r = r | (256'(hist[idx] & mask) << (j * ew));
      end
      return r;
   endfunction

   task automatic acc(input int s, input logic [63:0] d, input int k, input int dil,
                      input int ew, input string tag);
      hist.push_back(d);
      step(s, 1'b0, 1'b1, d);
      last_exp = exp_taps(k, dil, ew);
      last_pr  = (hist.size() - 1) >= dil * (k - 1);
      check({tag, "_valid"}, 256'(gv), 256'(1'b1));
      check({tag, "_taps"}, gt, last_exp);
      check({tag, "_primed"}, 256'(gp), 256'(last_pr));
   endtask

   initial begin
      // Reset all instances together and check the cleared outputs.
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 5; s++) begin
         sel = s;
         #1;
         check("reset_valid", 256'(gv), 256'(1'b0));
         check("reset_taps", gt, 256'(0));
         check("reset_primed", 256'(gp), 256'(1'b0));
      end
      rst = '0;

      // A: back-to-back 1..7, then 8..10.
      hist.delete();
      for (int i = 1; i <= 7; i++) begin
         acc(0, 64'(i), 4, 2, 16, "a_stream");
         if (i == 6) begin
            check("a_sixth_taps", gt, 256'(64'h0006_0004_0002_0000));
            check("a_sixth_primed", 256'(gp), 256'(1'b0));
         end
      end
      check("a_seventh_taps", gt, 256'(64'h0007_0005_0003_0001));
      check("a_seventh_primed", 256'(gp), 256'(1'b1));
      for (int i = 8; i <= 10; i++) acc(0, 64'(i), 4, 2, 16, "a_stream");

      // A: reset with in_valid high drops the sample, then accept 100.
      step(0, 1'b1, 1'b1, 64'd99);
      check("a_rst_valid", 256'(gv), 256'(1'b0));
      check("a_rst_taps", gt, 256'(0));
      check("a_rst_primed", 256'(gp), 256'(1'b0));
      step(0, 1'b0, 1'b1, 64'd100);
      check("a_post_rst_valid", 256'(gv), 256'(1'b1));
`ifdef DTC_ZERO_MASK_EN
      check("a_post_rst_taps", gt, 256'(64'h0064_0000_0000_0000));
`else
      check("a_post_rst_taps", gt, 256'(64'h0064_0005_0009_0007));
`endif
      check("a_post_rst_primed", 256'(gp), 256'(1'b0));

      // G: 1..3, five idle cycles with outputs held, then 4.
      hist.delete();
      for (int i = 1; i <= 3; i++) acc(1, 64'(i), 4, 2, 16, "g_stream");
      for (int i = 0; i < 5; i++) begin
         step(1, 1'b0, 1'b0, 64'hDEAD);
         check("g_gap_valid", 256'(gv), 256'(1'b0));
         check("g_gap_taps", gt, 256'(64'h0003_0001_0000_0000));
         check("g_gap_primed", 256'(gp), 256'(1'b0));
      end
      acc(1, 64'd4, 4, 2, 16, "g_resume");
      check("g_resume_hand", gt, 256'(64'h0004_0002_0000_0000));

      // B: non-power-of-2 ring, 1..20 across several head wraps.
      hist.delete();
      for (int i = 1; i <= 20; i++) acc(2, 64'(i), 3, 3, 16, "b_stream");
      check("b_last_hand", gt, 256'(48'h0014_0011_000E));

      // C: single-entry ring.
      hist.delete();
      acc(3, 64'd1, 2, 1, 16, "c_first");
      check("c_first_primed", 256'(gp), 256'(1'b0));
      acc(3, 64'd2, 2, 1, 16, "c_second");
      check("c_second_hand", gt, 256'(32'h0002_0001));
      check("c_second_primed", 256'(gp), 256'(1'b1));
      for (int i = 3; i <= 6; i++) acc(3, 64'(i), 2, 1, 16, "c_stream");

      // R: default parameters, random valid and data against the history model.
      hist.delete();
      last_exp = '0;
      last_pr  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            acc(4, {$urandom, $urandom}, 4, 4, 64, "r_beat");
         end else begin
            step(4, 1'b0, 1'b0, {$urandom, $urandom});
            check("r_idle_valid", 256'(gv), 256'(1'b0));
            check("r_idle_taps", gt, last_exp);
            check("r_idle_primed", 256'(gp), 256'(last_pr));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
